// File: rtl/bomba_actuador_if.sv
// ---------------------------------------------------------------------------
// bomba_actuador_if
// Groups the signals between the pump level controller, the operator input
// and the actuator stage that drives the board I/O.
//   bomba_req_i : pump request (controller's bomba_o)
//   alarma_i    : alarm (controller's alarma_o)
//   ack_i       : operator fault acknowledge, level-sensitive
//   motor_o     : motor contactor drive, 1 = on
//   buzzer_o    : blinking buzzer drive
//   falla_o     : latched over-run fault
//   estado_o    : current state code for debug/LEDs
// master : controller/operator side (drives the requests, reads the outputs)
// slave  : actuator stage (bomba_actuador)
// ---------------------------------------------------------------------------
interface bomba_actuador_if;
    logic       bomba_req_i;
    logic       alarma_i;
    logic       ack_i;
    logic       motor_o;
    logic       buzzer_o;
    logic       falla_o;
    logic [2:0] estado_o;

    modport master (
        output bomba_req_i, alarma_i, ack_i,
        input  motor_o, buzzer_o, falla_o, estado_o
    );

    modport slave (
        input  bomba_req_i, alarma_i, ack_i,
        output motor_o, buzzer_o, falla_o, estado_o
    );
endinterface

// File: rtl/bomba_actuador.sv
// ---------------------------------------------------------------------------
// bomba_actuador
// Actuator stage after the pump level controller. Applies a start delay,
// enforces a minimum off time after every run or fault, and latches a fault
// when the motor runs longer than T_MAX_RUN cycles. Drives the buzzer with a
// square wave while an alarm or fault is present.
//
// Ports:
//   ck          : system clock, rising edge
//   rst_i       : asynchronous active-low reset
//   bus         : bomba_actuador_if.slave (requests in, motor/buzzer/fault out)
//   arranques_o : [15:0] saturating count of completed starts
//                 (present only when BOMBA_CONTADOR_EN is defined)
//
// Optional feature macro: BOMBA_CONTADOR_EN
// ---------------------------------------------------------------------------
module bomba_actuador #(
    parameter int CNT_W      = 16,
    parameter int T_ARRANQUE = 4,
    parameter int T_MIN_OFF  = 8,
    parameter int T_MAX_RUN  = 64,
    parameter int T_BLINK    = 4
) (
    input  logic              ck,
    input  logic              rst_i,
    bomba_actuador_if.slave   bus
`ifdef BOMBA_CONTADOR_EN
    ,
    output logic [15:0]       arranques_o
`endif
);

    typedef enum logic [2:0] {
        REPOSO       = 3'd0,
        ARRANQUE     = 3'd1,
        MARCHA       = 3'd2,
        ENFRIAMIENTO = 3'd3,
        FALLA        = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] UNO        = CNT_W'(1);
    localparam logic [CNT_W-1:0] FIN_ARR    = CNT_W'(T_ARRANQUE - 1);
    localparam logic [CNT_W-1:0] FIN_OFF    = CNT_W'(T_MIN_OFF - 1);
    localparam logic [CNT_W-1:0] FIN_RUN    = CNT_W'(T_MAX_RUN - 1);
    localparam logic [CNT_W-1:0] FIN_BLINK  = CNT_W'(T_BLINK - 1);

    state_t             estado_q;
    state_t             estado_d;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   timer_d;
    logic [CNT_W-1:0]   blink_q;
    logic               activo_q;
    logic               motor_q;
    logic               falla_q;
    logic               buzzer_q;
    logic               buzz_activo;

    // Next-state and timer logic. Every exit reloads the timer to 0, so it
    // never gets near wrapping. In MARCHA an alarm or a dropped request takes
    // priority over the timeout. Illegal codes recover into FALLA.
    always_comb begin
        estado_d = estado_q;
        timer_d  = '0;
        case (estado_q)
            REPOSO: begin
                if (bus.bomba_req_i && !bus.alarma_i)
                    estado_d = ARRANQUE;
            end
            ARRANQUE: begin
                if (!bus.bomba_req_i || bus.alarma_i)
                    estado_d = REPOSO;
                else if (timer_q == FIN_ARR)
                    estado_d = MARCHA;
                else
                    timer_d = timer_q + UNO;
            end
            MARCHA: begin
                if (bus.alarma_i || !bus.bomba_req_i)
                    estado_d = ENFRIAMIENTO;
                else if (timer_q == FIN_RUN)
                    estado_d = FALLA;
                else
                    timer_d = timer_q + UNO;
            end
            ENFRIAMIENTO: begin
                if (timer_q == FIN_OFF)
                    estado_d = REPOSO;
                else
                    timer_d = timer_q + UNO;
            end
            FALLA: begin
                if (bus.ack_i && !bus.bomba_req_i)
                    estado_d = ENFRIAMIENTO;
            end
            default: begin
                estado_d = FALLA;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state so
    // they change on the same edge as the state code.
    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            estado_q <= REPOSO;
            timer_q  <= '0;
            motor_q  <= 1'b0;
            falla_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            motor_q  <= (estado_d == MARCHA);
            falla_q  <= (estado_d == FALLA);
        end
    end

    assign buzz_activo = bus.alarma_i || (estado_q == FALLA);

    // Buzzer blinker. activo_q marks that the previous cycle was already
    // active, so the first active cycle always starts high with a fresh count.
    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i) begin
            buzzer_q <= 1'b0;
            blink_q  <= '0;
            activo_q <= 1'b0;
        end else if (!buzz_activo) begin
            buzzer_q <= 1'b0;
            blink_q  <= '0;
            activo_q <= 1'b0;
        end else if (!activo_q) begin
            buzzer_q <= 1'b1;
            blink_q  <= '0;
            activo_q <= 1'b1;
        end else if (blink_q == FIN_BLINK) begin
            buzzer_q <= ~buzzer_q;
            blink_q  <= '0;
        end else begin
            blink_q  <= blink_q + UNO;
        end
    end

`ifdef BOMBA_CONTADOR_EN
    // Completed-start counter; only ARRANQUE can lead into MARCHA.
    always_ff @(posedge ck or negedge rst_i) begin
        if (!rst_i)
            arranques_o <= '0;
        else if (estado_q == ARRANQUE && estado_d == MARCHA && arranques_o != 16'hFFFF)
            arranques_o <= arranques_o + 16'd1;
    end
`endif

    assign bus.motor_o  = motor_q;
    assign bus.falla_o  = falla_q;
    assign bus.buzzer_o = buzzer_q;
    assign bus.estado_o = estado_q;

endmodule
